// File: rtl/ecc_pkg.sv
// Shared definitions for the ecc_enc_dec APB job master: FSM states, register
// map, op/width codes and the ordered write list.
package ecc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WAIT_DONE,
      S_RESULT
   } state_t;

   localparam logic [3:0] REG_CTRL     = 4'h0;
   localparam logic [3:0] REG_DATA_IN  = 4'h4;
   localparam logic [3:0] REG_CW_WIDTH = 4'h8;
   localparam logic [3:0] REG_NOISE    = 4'hC;

   localparam logic [1:0] OP_ENC  = 2'b00;
   localparam logic [1:0] OP_DEC  = 2'b01;
   localparam logic [1:0] OP_FULL = 2'b10;

   localparam logic [1:0] W_8  = 2'b00;
   localparam logic [1:0] W_16 = 2'b01;
   localparam logic [1:0] W_32 = 2'b10;

   // CTRL always goes last: its ACCESS phase is what starts ecc_enc_dec.
   function automatic logic [3:0] wr_reg(input logic [1:0] idx, input logic full);
      case (idx)
         2'd0:    wr_reg = REG_CW_WIDTH;
         2'd1:    wr_reg = REG_DATA_IN;
         2'd2:    wr_reg = full ? REG_NOISE : REG_CTRL;
         default: wr_reg = REG_CTRL;
      endcase
   endfunction

   function automatic logic wr_is_last(input logic [1:0] idx, input logic full);
      return full ? (idx == 2'd3) : (idx == 2'd2);
   endfunction

endpackage

// File: rtl/ecc_timeout_cnt.sv
// Saturating cycle counter used to bound the wait for operation_done.
module ecc_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !expired_o)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ecc_apb_job_master.sv
// Takes one ECC job, programs ecc_enc_dec over APB (CTRL last), waits for
// operation_done with a timeout, and returns the result on a valid/ready port.
module ecc_apb_job_master
   import ecc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned TIMEOUT_CYCLES  = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [1:0]                 job_ctrl,
   input  logic [1:0]                 job_width,
   input  logic [DATA_WIDTH-1:0]      job_data,
   input  logic [DATA_WIDTH-1:0]      job_noise,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   input  logic                       enc_op_done,
   input  logic [DATA_WIDTH-1:0]      enc_data_out,
   input  logic [1:0]                 enc_num_of_errors,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [DATA_WIDTH-1:0]      res_data,
   output logic [1:0]                 res_errors,
   output logic                       res_timeout
);
   state_t                     state_q;
   logic [1:0]                 wr_idx_q, ctrl_q, width_q;
   logic [DATA_WIDTH-1:0]      data_q, noise_q;
   logic                       job_ready_q, psel_q, penable_q, pwrite_q;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
   logic [AMBA_WORD-1:0]       pwdata_q;
   logic                       res_valid_q, res_timeout_q;
   logic [DATA_WIDTH-1:0]      res_data_q;
   logic [1:0]                 res_errors_q;

   logic [1:0]           wr_nxt_idx;
   logic [3:0]           wr_nxt_reg;
   logic [AMBA_WORD-1:0] wr_nxt_data;
   logic                 wr_last, tmo_expired;

   // ctrl=11 is handled as full channel, so bit 1 alone selects the NOISE write.
   always_comb begin
      wr_nxt_idx = wr_idx_q + 2'd1;
      wr_nxt_reg = wr_reg(wr_nxt_idx, ctrl_q[1]);
      wr_last    = wr_is_last(wr_idx_q, ctrl_q[1]);
      case (wr_nxt_reg)
         REG_CW_WIDTH: wr_nxt_data = AMBA_WORD'(width_q);
         REG_DATA_IN:  wr_nxt_data = AMBA_WORD'(data_q);
         REG_NOISE:    wr_nxt_data = AMBA_WORD'(noise_q);
         default:      wr_nxt_data = AMBA_WORD'(ctrl_q);
      endcase
   end

   ecc_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     ((state_q == S_ACCESS) && wr_last),
      .en_i      (state_q == S_WAIT_DONE),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wr_idx_q      <= '0;
         ctrl_q        <= '0;
         width_q       <= '0;
         data_q        <= '0;
         noise_q       <= '0;
         job_ready_q   <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_errors_q  <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (job_valid && job_ready_q) begin
                  ctrl_q      <= job_ctrl;
                  width_q     <= job_width;
                  data_q      <= job_data;
                  noise_q     <= job_noise;
                  wr_idx_q    <= '0;
                  job_ready_q <= 1'b0;
                  psel_q      <= 1'b1;
                  pwrite_q    <= 1'b1;
                  penable_q   <= 1'b0;
                  paddr_q     <= AMBA_ADDR_WIDTH'(REG_CW_WIDTH);
                  pwdata_q    <= AMBA_WORD'(job_width);
                  state_q     <= S_SETUP;
               end else begin
                  job_ready_q <= 1'b1;
               end
            end
            S_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (wr_last) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  pwrite_q  <= 1'b0;
                  pwdata_q  <= '0;
                  state_q   <= S_WAIT_DONE;
               end else begin
                  wr_idx_q  <= wr_nxt_idx;
                  penable_q <= 1'b0;
                  paddr_q   <= AMBA_ADDR_WIDTH'(wr_nxt_reg);
                  pwdata_q  <= wr_nxt_data;
                  state_q   <= S_SETUP;
               end
            end
            S_WAIT_DONE: begin
               if (enc_op_done) begin
                  res_valid_q   <= 1'b1;
                  res_data_q    <= enc_data_out;
                  res_errors_q  <= enc_num_of_errors;
                  res_timeout_q <= 1'b0;
                  state_q       <= S_RESULT;
               end else if (tmo_expired) begin
                  res_valid_q   <= 1'b1;
                  res_data_q    <= '0;
                  res_errors_q  <= '0;
                  res_timeout_q <= 1'b1;
                  state_q       <= S_RESULT;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  job_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign job_ready   = job_ready_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_errors  = res_errors_q;
   assign res_timeout = res_timeout_q;
endmodule
